// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
// Ports: clk/rst, start+dividend/divisor in; quotient/remainder/busy/done/div_by_zero out.
module seq_divider #(
  parameter int N_WIDTH = 48,
  parameter int D_WIDTH = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(N_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q;
  logic [N_WIDTH-1:0] q_q;
  logic [N_WIDTH-1:0] q_d;
  logic [D_WIDTH:0]   r_q;
  logic [D_WIDTH:0]   r_d;
  logic [D_WIDTH-1:0] dv_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [N_WIDTH-1:0] quot_q;
  logic [D_WIDTH-1:0] rem_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic [D_WIDTH:0]   t;
  logic               ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t     = {r_q[D_WIDTH-1:0], q_q[N_WIDTH-1]};
    ge    = (t >= {1'b0, dv_q});
    r_d   = ge ? (t - {1'b0, dv_q}) : t;
    q_d   = {q_q[N_WIDTH-2:0], ge};
    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= '0;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= dividend;
              dv_q    <= divisor;
              r_q     <= '0;
              cnt_q   <= CW'(N_WIDTH);
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            quot_q  <= q_d;
            rem_q   <= r_d[D_WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider.
// Reference results come from plain integer / and % on the sampled operands.
module tb_seq_divider;

  localparam int NW = 48;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_divider #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  function automatic logic [NW-1:0] ref_q(input logic [NW-1:0] a,
                                          input logic [DW-1:0] b);
    if (b == '0) return '1;
    return a / NW'(b);
  endfunction

  function automatic logic [DW-1:0] ref_r(input logic [NW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [NW-1:0] m;
    if (b == '0) return '0;
    m = a % NW'(b);
    return m[DW-1:0];
  endfunction

  function automatic int ref_lat(input logic [DW-1:0] b);
    return (b == '0) ? 1 : NW + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation; inputs are scrambled right after acceptance.
  // Returns cycle count to done (1 = cycle after accept edge), busy cycle
  // count over that window, and the quotient seen in the first busy cycle.
  task automatic do_op(input logic [NW-1:0] a, input logic [DW-1:0] b,
                       output int lat, output int bcnt,
                       output logic [NW-1:0] qmid);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = DW'($urandom);
    lat  = 1;
    bcnt = busy ? 1 : 0;
    qmid = quotient;
    while (!done && lat < 200) begin
      step();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) step();
    checks++;
    if (quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_data got q=%h r=%h exp 0/0", quotient, remainder);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got b=%b d=%b z=%b exp 000",
               busy, done, div_by_zero);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [NW-1:0] qm;
    do_op(48'd100, 18'd7, lat, bcnt, qm);
    checks++;
    if (quotient !== 48'd14 || remainder !== 18'd2 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_val got q=%0d r=%0d z=%b exp 14/2/0",
               quotient, remainder, div_by_zero);
    end
    checks++;
    if (lat != 49 || bcnt != 49) begin
      errors++;
      $display("FAIL basic_timing got lat=%0d busy=%0d exp 49/49", lat, bcnt);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got b=%b d=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_boundary();
    int lat, bcnt;
    logic [NW-1:0] qm, a;
    logic [DW-1:0] b;
    a = '1;
    b = 18'd1;
    do_op(a, b, lat, bcnt, qm);
    checks++;
    if (quotient !== a || remainder !== '0) begin
      errors++;
      $display("FAIL max_div1 got q=%h r=%h exp %h/0", quotient, remainder, a);
    end
    step();
    b = '1;
    do_op(a, b, lat, bcnt, qm);
    checks++;
    if (quotient !== ref_q(a, b) || remainder !== ref_r(a, b)) begin
      errors++;
      $display("FAIL max_divmax got q=%h r=%h exp %h/%h",
               quotient, remainder, ref_q(a, b), ref_r(a, b));
    end
    step();
    do_op(48'd5, 18'd9, lat, bcnt, qm);
    checks++;
    if (quotient !== '0 || remainder !== 18'd5) begin
      errors++;
      $display("FAIL small_div got q=%0d r=%0d exp 0/5", quotient, remainder);
    end
    step();
    do_op(48'd1234, 18'd0, lat, bcnt, qm);
    checks++;
    if (quotient !== {NW{1'b1}} || remainder !== '0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div0_val got q=%h r=%h z=%b exp ones/0/1",
               quotient, remainder, div_by_zero);
    end
    checks++;
    if (lat != 1 || bcnt != 1) begin
      errors++;
      $display("FAIL div0_timing got lat=%0d busy=%0d exp 1/1", lat, bcnt);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL div0_after got b=%b d=%b z=%b exp 0/0/1",
               busy, done, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic [NW-1:0] qm;
    dividend = 48'd1000;
    divisor  = 18'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == 10 || lat == 30) begin
        start    = 1'b1;
        dividend = 48'd50;
        divisor  = 18'd5;
      end
      step();
      start = 1'b0;
      lat++;
    end
    checks++;
    if (quotient !== 48'd333 || remainder !== 18'd1 || lat != 49) begin
      errors++;
      $display("FAIL ignore_start got q=%0d r=%0d lat=%0d exp 333/1/49",
               quotient, remainder, lat);
    end
    step();
    do_op(48'd200, 18'd6, lat, bcnt, qm);
    checks++;
    if (quotient !== 48'd33 || remainder !== 18'd2 || lat != 49) begin
      errors++;
      $display("FAIL back_to_back got q=%0d r=%0d lat=%0d exp 33/2/49",
               quotient, remainder, lat);
    end
    checks++;
    if (qm !== 48'd333) begin
      errors++;
      $display("FAIL hold_result got q=%0d exp 333", qm);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [NW-1:0] qm;
    logic saw_done;
    dividend = 48'd1000;
    divisor  = 18'd7;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got q=%h r=%h b=%b d=%b z=%b exp all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (60) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet got activity=1 exp 0");
    end
    do_op(48'd81, 18'd9, lat, bcnt, qm);
    checks++;
    if (quotient !== 48'd9 || remainder !== '0 || lat != 49) begin
      errors++;
      $display("FAIL after_reset got q=%0d r=%0d lat=%0d exp 9/0/49",
               quotient, remainder, lat);
    end
    step();
  endtask

  task automatic test_random();
    int lat, bcnt, sel;
    logic [NW-1:0] qm, a, prev_q;
    logic [DW-1:0] b;
    prev_q = 48'd9;
    for (int i = 0; i < 1000; i++) begin
      a = NW'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) a = NW'($urandom_range(0, 1000));
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel <= 2) b = DW'($urandom_range(1, 15));
      else               b = DW'($urandom);
      do_op(a, b, lat, bcnt, qm);
      checks++;
      if (quotient !== ref_q(a, b) || remainder !== ref_r(a, b) ||
          div_by_zero !== (b == '0)) begin
        errors++;
        $display("FAIL rand_val a=%h b=%h got q=%h r=%h z=%b exp q=%h r=%h",
                 a, b, quotient, remainder, div_by_zero,
                 ref_q(a, b), ref_r(a, b));
      end
      checks++;
      if (lat != ref_lat(b) || bcnt != ref_lat(b)) begin
        errors++;
        $display("FAIL rand_timing b=%h got lat=%0d busy=%0d exp %0d",
                 b, lat, bcnt, ref_lat(b));
      end
      if (b != '0) begin
        checks++;
        if (qm !== prev_q) begin
          errors++;
          $display("FAIL rand_hold got q=%h exp %h", qm, prev_q);
        end
      end
      prev_q = ref_q(a, b);
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
